// File: rtl/dvl_item_arb.sv
// Round-robin item arbiter with lock-until-last onto one registered output channel; optional DVL_ITEM_ARB_PRIO_EN adds req_prio.
// Latency: one cycle from accepted request beat to out_*.
// Backpressure: req_ready drops whenever the output register is full and out_ready is low.
module dvl_item_arb #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 32,
   localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   input  logic [N_REQ-1:0]        req_last,
`ifdef DVL_ITEM_ARB_PRIO_EN
   input  logic [N_REQ-1:0]        req_prio,
`endif
   output logic [N_REQ-1:0]        req_ready,
   output logic                    out_valid,
   output logic [DATA_W-1:0]       out_data,
   output logic                    out_last,
   output logic [ID_W-1:0]         out_id,
   input  logic                    out_ready,
   output logic                    busy
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_LOCK = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
   logic [ID_W-1:0]   out_id_q, out_id_d;

   logic [N_REQ-1:0]  cand;
   logic [N_REQ-1:0]  grant;
   logic [ID_W-1:0]   gnt_idx;
   logic [ID_W-1:0]   idx;
   logic              found;
   logic              load_en;
   logic              accept;
   logic [DATA_W-1:0] acc_data;
   logic              acc_last;

   // While locked the grant is pinned to ptr_q, which holds the locked requester.
   always_comb begin
      cand = req_valid;
`ifdef DVL_ITEM_ARB_PRIO_EN
      if (|(req_valid & req_prio)) cand = req_valid & req_prio;
`endif
      grant   = '0;
      gnt_idx = ptr_q;
      idx     = '0;
      found   = 1'b0;
      if (state_q == S_LOCK) begin
         grant[ptr_q] = 1'b1;
      end else begin
         for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(ptr_q) + k) % N_REQ);
            if (!found && cand[idx]) begin
               found      = 1'b1;
               gnt_idx    = idx;
               grant[idx] = 1'b1;
            end
         end
      end
   end

   assign load_en   = !out_valid_q | out_ready;
   assign req_ready = rst ? '0 : (grant & {N_REQ{load_en}});
   assign accept    = |(req_valid & req_ready);

   always_comb begin
      acc_data = '0;
      acc_last = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            acc_data = req_data[i*DATA_W +: DATA_W];
            acc_last = req_last[i];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_id_d    = out_id_q;
      if (load_en) begin
         out_valid_d = accept;
         if (accept) begin
            out_data_d = acc_data;
            out_last_d = acc_last;
            out_id_d   = gnt_idx;
         end
      end
      if (accept) begin
         ptr_d   = gnt_idx;
         state_d = acc_last ? S_IDLE : S_LOCK;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= ID_W'(N_REQ - 1);
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_id_q    <= out_id_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_id    = out_id_q;
   assign busy      = (state_q == S_LOCK);

endmodule

// File: tb/tb_dvl_item_arb.sv
// Directed bench for dvl_item_arb (N_REQ=4, DATA_W=32); inputs driven just after posedge, outputs sampled on negedge.
module tb_dvl_item_arb;
   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid, req_last, req_ready;
   logic [31:0]  d [4];
   logic [127:0] req_data;
   logic         out_valid, out_last, out_ready, busy;
   logic [31:0]  out_data;
   logic [1:0]   out_id;
`ifdef DVL_ITEM_ARB_PRIO_EN
   logic [3:0]   req_prio;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] sbq [$];
   logic [31:0] exp_d;
   logic [31:0] seq;
   int          drained;
   logic        acc;

   always #5 clk = ~clk;
   assign req_data = {d[3], d[2], d[1], d[0]};

   dvl_item_arb #(.N_REQ(4), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
`ifdef DVL_ITEM_ARB_PRIO_EN
      .req_prio  (req_prio),
`endif
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_id    (out_id),
      .out_ready (out_ready),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_last  = '0;
      out_ready = 1'b1;
`ifdef DVL_ITEM_ARB_PRIO_EN
      req_prio  = '0;
`endif
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 4'hF;
      req_last  = 4'hF;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) d[i] = 32'h0;
`ifdef DVL_ITEM_ARB_PRIO_EN
      req_prio  = '0;
`endif
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_id", out_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      cyc();
      rst = 1'b0;

      // plain round robin, one beat per cycle
      for (int i = 0; i < 4; i++) d[i] = 32'h100 + i;
      for (int k = 0; k < 6; k++) begin
         smp();
         chk("rr_ready", req_ready, 4'b0001 << (k % 4));
         if (k == 0) begin
            chk("rr_first_empty", out_valid, 0);
         end else begin
            chk("rr_valid", out_valid, 1);
            chk("rr_id", out_id, (k - 1) % 4);
            chk("rr_data", out_data, 32'h100 + ((k - 1) % 4));
         end
         cyc();
      end

      // multi-beat lock on requester 2, with a valid gap mid-item
      do_reset();
      req_valid = 4'b0100; req_last = 4'b0000; d[2] = 32'h201;
      smp();
      chk("lk_a_ready", req_ready, 4'b0100);
      chk("lk_a_busy", busy, 0);
      cyc();
      req_valid = 4'b1111; req_last = 4'b1011; d[2] = 32'h202;
      smp();
      chk("lk_b_busy", busy, 1);
      chk("lk_b_ready", req_ready, 4'b0100);
      chk("lk_b_id", out_id, 2);
      chk("lk_b_data", out_data, 32'h201);
      chk("lk_b_last", out_last, 0);
      cyc();
      req_valid = 4'b1011;
      smp();
      chk("lk_gap_busy", busy, 1);
      chk("lk_gap_ready", req_ready, 4'b0100);
      chk("lk_gap_data", out_data, 32'h202);
      cyc();
      req_valid = 4'b1111; req_last = 4'b1111; d[2] = 32'h203;
      smp();
      chk("lk_c_busy", busy, 1);
      chk("lk_c_ready", req_ready, 4'b0100);
      chk("lk_c_bubble", out_valid, 0);
      cyc();
      req_valid = 4'b1011;
      smp();
      chk("lk_d_busy", busy, 0);
      chk("lk_d_ready", req_ready, 4'b1000);
      chk("lk_d_id", out_id, 2);
      chk("lk_d_data", out_data, 32'h203);
      chk("lk_d_last", out_last, 1);
      cyc();
      smp();
      chk("lk_e_id", out_id, 3);
      chk("lk_e_ready", req_ready, 4'b0001);

      // output stall for 5 cycles, then drain+load together
      do_reset();
      out_ready = 1'b0; req_valid = 4'b0001; req_last = 4'hF; d[0] = 32'h300;
      smp();
      chk("st_first_ready", req_ready, 4'b0001);
      cyc();
      req_valid = 4'hF;
      for (int i = 0; i < 4; i++) d[i] = 32'h310 + i;
      for (int k = 0; k < 5; k++) begin
         smp();
         chk("st_ready", req_ready, 0);
         chk("st_valid", out_valid, 1);
         chk("st_data", out_data, 32'h300);
         cyc();
      end
      out_ready = 1'b1;
      smp();
      chk("st_rel_ready", req_ready, 4'b0010);
      cyc();
      smp();
      chk("st_nobubble", out_valid, 1);
      chk("st_next_id", out_id, 1);
      chk("st_next_data", out_data, 32'h311);

      // asynchronous reset mid-lock
      do_reset();
      req_valid = 4'b0100; req_last = 4'b0000; d[2] = 32'h400;
      smp();
      chk("ar_ready", req_ready, 4'b0100);
      cyc();
      smp();
      chk("ar_busy_pre", busy, 1);
      chk("ar_valid_pre", out_valid, 1);
      #1 rst = 1'b1;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_busy", busy, 0);
      chk("ar_ready_in_rst", req_ready, 0);
      chk("ar_data", out_data, 0);
      cyc();
      rst = 1'b0; req_valid = 4'hF; req_last = 4'hF;
      smp();
      chk("ar_first_ready", req_ready, 4'b0001);
      chk("ar_busy_post", busy, 0);
      cyc();
      smp();
      chk("ar_first_id", out_id, 0);

      // single requester, toggling out_ready, scoreboarded
      do_reset();
      req_valid = 4'b0010; req_last = 4'hF;
      seq = 32'h500; d[1] = seq; drained = 0;
      for (int k = 0; k < 10; k++) begin
         out_ready = (k % 2 == 0);
         smp();
         acc = req_ready[1];
         if (acc) sbq.push_back(d[1]);
         if (out_valid && out_ready) begin
            exp_d = (sbq.size() > 0) ? sbq.pop_front() : 32'hDEAD_BEEF;
            chk("sb_data", out_data, exp_d);
            chk("sb_id", out_id, 1);
            drained++;
         end
         cyc();
         if (acc) begin
            seq = seq + 1;
            d[1] = seq;
         end
      end
      chk("sb_drained", drained, 4);
      chk("sb_pending", sbq.size(), 1);

`ifdef DVL_ITEM_ARB_PRIO_EN
      do_reset();
      req_valid = 4'hF; req_last = 4'hF; req_prio = 4'b1000;
      for (int k = 0; k < 3; k++) begin
         smp();
         chk("pr_ready", req_ready, 4'b1000);
         cyc();
      end
      req_prio = 4'b0000;
      smp();
      chk("pr_resume0", req_ready, 4'b0001);
      cyc();
      smp();
      chk("pr_resume1", req_ready, 4'b0010);
      cyc();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
